apb_uart_completer: RTL and testbench

APB_UART_COMPLETER -- requirements
Module: apb_uart_completer

---
 rtl/apb_uart_completer.sv | 157 +++++++++++++++
 tb/tb_apb_uart_completer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_completer.sv
// APB completer bridging a CPU bus to UART TX/RX FIFOs.
// Ports: APB (PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
//        PRDATA, PREADY, PSLVERR); FIFO side (tx_full, rx_empty,
//        r_data, wr_uart, w_data, rd_uart); irq (registered).
module apb_uart_completer #(
    parameter int          ADDR_W = 32,
    parameter logic [3:0]  TO_RST = 4'hF
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              tx_full,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              rd_uart,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        STALL
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       en_rx_q;
    logic       en_tx_q;
    logic [3:0] to_q;
    logic       tx_ovf_q;
    logic       rx_unf_q;
    logic       irq_q;

    logic [3:0] off;
    logic       sel_data;
    logic       sel_stat;
    logic       sel_ctrl;
    logic       active;
    logic       blocked;
    logic       expired;
    logic       set_ovf;
    logic       set_unf;
    logic       clr_ovf;
    logic       clr_unf;
    logic       ctrl_wr;

    // Address bits above the decoded nibble and the unused
    // write-data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{PADDR[ADDR_W-1:4], PWDATA[31:8]};

    assign off      = PADDR[3:0];
    assign sel_data = (off == 4'h0);
    assign sel_stat = (off == 4'h4);
    assign sel_ctrl = (off == 4'h8);

    // Dropping PSEL mid-transfer kills every side effect at once.
    assign active  = (state_q != IDLE) && PSEL;
    assign blocked = sel_data && (PWRITE ? tx_full : rx_empty);
    // The access cycle itself counts as wait 0, so a timeout of
    // 0 errors without ever stalling.
    assign expired = (cnt_q == to_q);

    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0;
        wr_uart = 1'b0;
        rd_uart = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (active) begin
            if (!sel_data) begin
                PREADY  = 1'b1;
                PSLVERR = !(sel_stat || sel_ctrl);
                if (!PWRITE && sel_stat) begin
                    PRDATA = {28'h0, rx_unf_q, tx_ovf_q,
                              rx_empty, tx_full};
                end else if (!PWRITE && sel_ctrl) begin
                    PRDATA = {24'h0, to_q, 2'b00,
                              en_tx_q, en_rx_q};
                end
            end else if (!blocked) begin
                // Freeing in the expiry cycle lands here: success wins.
                PREADY  = 1'b1;
                wr_uart = PWRITE;
                rd_uart = !PWRITE;
                if (!PWRITE) begin
                    PRDATA = {24'h0, r_data};
                end
            end else if (expired) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
                set_ovf = PWRITE;
                set_unf = !PWRITE;
            end
        end
    end

    assign w_data  = wr_uart ? PWDATA[7:0] : 8'h00;
    assign ctrl_wr = active && PWRITE && sel_ctrl;
    assign clr_ovf = active && PWRITE && sel_stat && PWDATA[2];
    assign clr_unf = active && PWRITE && sel_stat && PWDATA[3];
    assign irq     = irq_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= 4'h0;
            en_rx_q  <= 1'b0;
            en_tx_q  <= 1'b0;
            to_q     <= TO_RST;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_q <= ACCESS;
                        cnt_q   <= 4'h0;
                    end
                end
                ACCESS, STALL: begin
                    if (!PSEL || PREADY) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= STALL;
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (ctrl_wr) begin
                en_rx_q <= PWDATA[0];
                en_tx_q <= PWDATA[1];
                to_q    <= PWDATA[7:4];
            end
            // A set in the same cycle as a W1C clear wins.
            tx_ovf_q <= set_ovf || (tx_ovf_q && !clr_ovf);
            rx_unf_q <= set_unf || (rx_unf_q && !clr_unf);
            irq_q    <= (en_rx_q && !rx_empty)
                     || (en_tx_q && !tx_full)
                     || tx_ovf_q || rx_unf_q;
        end
    end

endmodule

// File: tb/tb_apb_uart_completer.sv
// Directed bench for apb_uart_completer.
// Drives APB transfers against a scripted FIFO model.
module tb_apb_uart_completer;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        tx_full;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        rd_uart;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    apb_uart_completer #(
        .ADDR_W(32),
        .TO_RST(4'hF)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .tx_full (tx_full),
        .rx_empty(rx_empty),
        .r_data  (r_data),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .rd_uart (rd_uart),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    // One APB transfer; starts just after a rising edge.
    task automatic xfer(input  logic [31:0] a,
                        input  logic        w,
                        input  logic [31:0] d,
                        output logic [31:0] rdat,
                        output logic        err,
                        output int          waits,
                        output int          wp,
                        output int          rp,
                        output logic [7:0]  wd);
        logic done;
        done  = 1'b0;
        rdat  = 32'h0;
        err   = 1'b0;
        waits = 0;
        wp    = 0;
        rp    = 0;
        wd    = 8'h00;
        PADDR   = a;
        PWRITE  = w;
        PWDATA  = d;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (wr_uart) begin
                wp++;
                wd = w_data;
            end
            if (rd_uart) rp++;
            if (PREADY) begin
                rdat = PRDATA;
                err  = PSLVERR;
                done = 1'b1;
                break;
            end
            waits++;
            @(posedge PCLK);
            #1;
        end
        chk("xfer_done", {31'h0, done}, 32'h1);
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          wt;
    int          np;
    int          nr;
    logic [7:0]  wd;

    initial begin
        PRESETn  = 1'b0;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = 32'h0;
        PWDATA   = 32'h0;
        tx_full  = 1'b0;
        rx_empty = 1'b0;
        r_data   = 8'h00;
        #12;
        chk("rst_pready", {31'h0, PREADY}, 32'h0);
        chk("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pulses", {30'h0, wr_uart, rd_uart}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;

        xfer(32'h8, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("ctrl_rst", rd, 32'h0000_00F0);

        // Zero-wait push.
        xfer(32'h0, 1'b1, 32'h0000_00A5, rd, er, wt, np, nr, wd);
        chk("wr_waits", wt, 0);
        chk("wr_err", {31'h0, er}, 32'h0);
        chk("wr_pulses", np, 1);
        chk("wr_data", {24'h0, wd}, 32'hA5);
        @(negedge PCLK);
        chk("wr_idle", {31'h0, wr_uart}, 32'h0);

        // Read stalls for 3 cycles until RX data shows up.
        rx_empty = 1'b1;
        r_data   = 8'h3C;
        fork
            begin
                repeat (4) @(posedge PCLK);
                #1 rx_empty = 1'b0;
            end
        join_none
        xfer(32'h0, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("rd_waits", wt, 3);
        chk("rd_data", rd, 32'h3C);
        chk("rd_pulses", nr, 1);
        chk("rd_err", {31'h0, er}, 32'h0);
        chk("rd_nowr", np, 0);

        // CTRL masks unused bits.
        xfer(32'h8, 1'b1, 32'hFFFF_FFFF, rd, er, wt, np, nr, wd);
        xfer(32'h8, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("ctrl_mask", rd, 32'h0000_00F3);

        // Timeout 2 with TX held full.
        xfer(32'h8, 1'b1, 32'h0000_0020, rd, er, wt, np, nr, wd);
        tx_full = 1'b1;
        xfer(32'h0, 1'b1, 32'h0000_0011, rd, er, wt, np, nr, wd);
        chk("to_waits", wt, 2);
        chk("to_err", {31'h0, er}, 32'h1);
        chk("to_nopush", np, 0);
        xfer(32'h4, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("stat_ovf", rd, 32'h5);
        chk("irq_ovf", {31'h0, irq}, 32'h1);
        xfer(32'h4, 1'b1, 32'h0000_0004, rd, er, wt, np, nr, wd);
        xfer(32'h4, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("stat_w1c", rd, 32'h1);

        // Resource frees on the expiry cycle: success wins.
        fork
            begin
                repeat (3) @(posedge PCLK);
                #1 tx_full = 1'b0;
            end
        join_none
        xfer(32'h0, 1'b1, 32'h0000_005A, rd, er, wt, np, nr, wd);
        chk("tie_waits", wt, 2);
        chk("tie_err", {31'h0, er}, 32'h0);
        chk("tie_push", np, 1);
        chk("tie_data", {24'h0, wd}, 32'h5A);

        // Invalid offset.
        xfer(32'hC, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("inv_waits", wt, 0);
        chk("inv_err", {31'h0, er}, 32'h1);
        chk("inv_data", rd, 32'h0);
        xfer(32'hC, 1'b1, 32'hFFFF_FFFF, rd, er, wt, np, nr, wd);
        chk("invw_err", {31'h0, er}, 32'h1);
        chk("invw_pulse", np + nr, 0);
        xfer(32'h8, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("inv_ctrl", rd, 32'h20);

        // irq follows RX not-empty one cycle later.
        rx_empty = 1'b1;
        xfer(32'h8, 1'b1, 32'h0000_0001, rd, er, wt, np, nr, wd);
        @(negedge PCLK);
        chk("irq_low", {31'h0, irq}, 32'h0);
        @(posedge PCLK);
        #1 rx_empty = 1'b0;
        @(negedge PCLK);
        chk("irq_same", {31'h0, irq}, 32'h0);
        @(negedge PCLK);
        chk("irq_rise", {31'h0, irq}, 32'h1);

        // Timeout 0: blocked read errors immediately.
        rx_empty = 1'b1;
        xfer(32'h0, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("to0_waits", wt, 0);
        chk("to0_err", {31'h0, er}, 32'h1);
        chk("to0_nopop", nr, 0);
        chk("to0_data", rd, 32'h0);
        xfer(32'h4, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("stat_unf", rd, 32'hA);

        // Reset in the middle of a stalled read.
        xfer(32'h8, 1'b1, 32'h0000_00F2, rd, er, wt, np, nr, wd);
        PADDR   = 32'h0;
        PWRITE  = 1'b0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        @(negedge PCLK);
        chk("ms_stall0", {31'h0, PREADY}, 32'h0);
        @(negedge PCLK);
        chk("ms_stall1", {31'h0, PREADY}, 32'h0);
        chk("ms_irq_pre", {31'h0, irq}, 32'h1);
        #2 PRESETn = 1'b0;
        #1;
        chk("ms_pready", {31'h0, PREADY}, 32'h0);
        chk("ms_pslverr", {31'h0, PSLVERR}, 32'h0);
        chk("ms_prdata", PRDATA, 32'h0);
        chk("ms_pulses", {30'h0, wr_uart, rd_uart}, 32'h0);
        chk("ms_irq", {31'h0, irq}, 32'h0);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        rx_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("ms_nopop", {31'h0, rd_uart}, 32'h0);
        end
        @(posedge PCLK);
        #1;
        xfer(32'h8, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("ctrl_rst2", rd, 32'h0000_00F0);
        xfer(32'h4, 1'b0, 32'h0, rd, er, wt, np, nr, wd);
        chk("stat_rst2", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
